// File: rtl/pbkdf2_ctrl.sv
// pbkdf2_ctrl: sequences a single hmac datapath through one PBKDF2-HMAC-SHA512
// block. T = U1 ^ U2 ^ ... ^ Uc. U1 = HMAC(P, salt || INT(block_idx)).
// Uj = HMAC(P, Uj-1). The hmac is restarted for every iteration.
// The password bus bypasses this block and must stay stable while busy.
module pbkdf2_ctrl #(
  parameter int ITER_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] iters,
  input  logic [255:0]      salt,
  input  logic [31:0]       block_idx,
  output logic              busy,
  output logic              done,
  output logic [511:0]      dk,
  output logic              hmac_rst_n,
  output logic              hmac_mode,
  output logic [511:0]      hmac_msg,
  input  logic              hmac_done,
  input  logic [511:0]      hmac_oH
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_ACCUM  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ITER_W-1:0] iters_q, iters_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic [255:0]      salt_q, salt_d;
  logic [31:0]       idx_q, idx_d;
  logic [511:0]      t_q, t_d;
  logic [511:0]      u_q, u_d;
  logic [511:0]      dk_q, dk_d;
  logic              mode_q, mode_d;
  logic              done_q, done_d;
  logic              rst_n_q, rst_n_d;
  logic [511:0]      t_next;

  // Next-state and datapath updates for the iteration sequencer
  always_comb begin
    state_d = state_q;
    iters_d = iters_q;
    cnt_d   = cnt_q;
    salt_d  = salt_q;
    idx_d   = idx_q;
    t_d     = t_q;
    u_d     = u_q;
    dk_d    = dk_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    t_next  = t_q ^ hmac_oH;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          iters_d = (iters == '0) ? ITER_W'(1) : iters;
          salt_d  = salt;
          idx_d   = block_idx;
          t_d     = '0;
          cnt_d   = ITER_W'(1);
          mode_d  = 1'b0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (hmac_done) begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        u_d = hmac_oH;
        t_d = t_next;
        if (cnt_q == iters_q) begin
          dk_d    = t_next;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d   = cnt_q + ITER_W'(1);
          mode_d  = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    rst_n_d = (state_d == S_RUN) || (state_d == S_ACCUM);
  end

  // State registers with synchronous reset; hmac reset is registered to stay glitch-free
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      iters_q <= '0;
      cnt_q   <= '0;
      salt_q  <= '0;
      idx_q   <= '0;
      t_q     <= '0;
      u_q     <= '0;
      dk_q    <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      rst_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      iters_q <= iters_d;
      cnt_q   <= cnt_d;
      salt_q  <= salt_d;
      idx_q   <= idx_d;
      t_q     <= t_d;
      u_q     <= u_d;
      dk_q    <= dk_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      rst_n_q <= rst_n_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign dk         = dk_q;
  assign hmac_rst_n = rst_n_q;
  assign hmac_mode  = mode_q;
  assign hmac_msg   = mode_q ? u_q : {salt_q, idx_q, 224'd0};

endmodule

// File: tb/tb_pbkdf2_ctrl.sv
// tb_pbkdf2_ctrl: directed bench for pbkdf2_ctrl driving a mock hmac whose
// k-th call of a job returns 512'hk. Expected calls and dk are queued when a
// job is launched and compared when the job completes.
module tb_pbkdf2_ctrl;

  localparam int ITER_W = 32;
  localparam int MAXC   = 15;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ITER_W-1:0] iters;
  logic [255:0]      salt;
  logic [31:0]       block_idx;
  logic              busy;
  logic              done;
  logic [511:0]      dk;
  logic              hmac_rst_n;
  logic              hmac_mode;
  logic [511:0]      hmac_msg;
  logic              hmac_done;
  logic [511:0]      hmac_oh;

  typedef struct packed {
    logic         mode;
    logic [511:0] msg;
  } call_t;

  call_t        exp_call_q[$];
  logic [511:0] exp_dk_q[$];

  int checks;
  int failures;
  int job_seq;
  bit rnd_h;
  bit stray_en;
  logic stray;

  // mock hmac state, written only by the mock process
  int           call_num;
  int           last_job;
  int           m_cnt;
  int           m_h;
  bit           m_active;
  bit           m_fin;
  logic         m_done_r;
  logic [511:0] m_oh_r;
  logic         obs_mode   [0:MAXC];
  logic [511:0] obs_msg    [0:MAXC];
  logic         obs_stable [0:MAXC];

  pbkdf2_ctrl #(.ITER_W(ITER_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .iters      (iters),
    .salt       (salt),
    .block_idx  (block_idx),
    .busy       (busy),
    .done       (done),
    .dk         (dk),
    .hmac_rst_n (hmac_rst_n),
    .hmac_mode  (hmac_mode),
    .hmac_msg   (hmac_msg),
    .hmac_done  (hmac_done),
    .hmac_oH    (hmac_oh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign hmac_done = m_done_r | stray;
  assign hmac_oh   = m_oh_r;

  // Stray done pulses whenever the controller holds the hmac in reset mid-job
  always @(negedge clk) begin
    stray <= stray_en && busy && !hmac_rst_n;
  end

  // Mock hmac: counts edges out of reset and raises done after H RUN cycles
  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      m_fin    = 1'b0;
      m_cnt    = 0;
      call_num = 0;
      last_job = job_seq;
      m_done_r <= 1'b0;
      m_oh_r   <= '0;
    end else begin
      if (job_seq != last_job) begin
        last_job = job_seq;
        call_num = 0;
      end
      if (!hmac_rst_n) begin
        m_active = 1'b0;
        m_fin    = 1'b0;
        m_cnt    = 0;
        m_done_r <= 1'b0;
      end else begin
        if (!m_active) begin
          m_active = 1'b1;
          m_fin    = 1'b0;
          m_cnt    = 0;
          call_num = call_num + 1;
          m_h      = rnd_h ? int'($urandom_range(20, 3)) : 5;
          if (call_num <= MAXC) begin
            obs_mode[call_num]   = hmac_mode;
            obs_msg[call_num]    = hmac_msg;
            obs_stable[call_num] = 1'b0;
          end
        end
        if (!m_fin) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == m_h - 1) begin
            m_fin = 1'b1;
            m_done_r <= 1'b1;
            m_oh_r   <= 512'(call_num);
            if (call_num <= MAXC) begin
              obs_stable[call_num] = (hmac_mode == obs_mode[call_num]) &&
                                     (hmac_msg == obs_msg[call_num]);
            end
          end
        end
      end
    end
  end

  task automatic checkVal(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch a job at a negedge and queue the calls and dk the mock should produce
  task automatic applyStimulus(input logic [ITER_W-1:0] it, input logic [255:0] s,
                               input logic [31:0] idx, output int ncalls);
    call_t        c;
    logic [511:0] acc;
    ncalls = (it == 0) ? 1 : int'(it);
    acc = '0;
    for (int k = 1; k <= ncalls; k++) begin
      c.mode = (k != 1);
      c.msg  = (k == 1) ? {s, idx, 224'd0} : 512'(k - 1);
      exp_call_q.push_back(c);
      acc = acc ^ 512'(k);
    end
    exp_dk_q.push_back(acc);
    iters     = it;
    salt      = s;
    block_idx = idx;
    job_seq++;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done, then compare dk, latency, busy span and every hmac call
  task automatic checkOutput(input string name, input int ncalls, input bit check_lat,
                             input bit pulse_start);
    int   cyc;
    int   busy_cnt;
    bit   got_done;
    call_t        ec;
    logic [511:0] edk;
    cyc      = 1;
    busy_cnt = 0;
    got_done = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (busy) busy_cnt++;
      if (done) begin
        got_done = 1'b1;
        start    = 1'b0;
        break;
      end
      if (pulse_start) begin
        start = ~start;
        iters = 9;
        salt  = '1;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    checkVal({name, "_done_seen"}, 512'(got_done), 512'(1));
    edk = (exp_dk_q.size() > 0) ? exp_dk_q.pop_front() : '0;
    checkVal({name, "_dk"}, dk, edk);
    if (check_lat) begin
      checkVal({name, "_latency"}, 512'(cyc), 512'(1 + ncalls * 7));
      checkVal({name, "_busy_cycles"}, 512'(busy_cnt), 512'(1 + ncalls * 7));
    end
    checkVal({name, "_calls"}, 512'(call_num), 512'(ncalls));
    for (int k = 1; k <= ncalls && k <= MAXC; k++) begin
      ec = (exp_call_q.size() > 0) ? exp_call_q.pop_front() : '0;
      checkVal($sformatf("%s_call%0d_mode", name, k), 512'(obs_mode[k]), 512'(ec.mode));
      checkVal($sformatf("%s_call%0d_msg", name, k), obs_msg[k], ec.msg);
      checkVal($sformatf("%s_call%0d_stable", name, k), 512'(obs_stable[k]), 512'(1));
    end
    exp_call_q.delete();
    @(negedge clk);
    checkVal({name, "_done_pulse"}, 512'(done), 512'(0));
    checkVal({name, "_busy_after"}, 512'(busy), 512'(0));
    @(negedge clk);
    @(negedge clk);
    checkVal({name, "_idle_hold"}, 512'(busy), 512'(0));
    checkVal({name, "_dk_hold"}, dk, edk);
  endtask

  // Directed job sequence
  initial begin
    int           nc;
    bit           hit;
    logic [255:0] s_bytes;
    checks    = 0;
    failures  = 0;
    job_seq   = 0;
    rnd_h     = 1'b0;
    stray_en  = 1'b0;
    reset     = 1'b1;
    start     = 1'b0;
    iters     = '0;
    salt      = '0;
    block_idx = '0;
    for (int i = 0; i < 32; i++) s_bytes[255 - 8*i -: 8] = 8'(i + 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst_busy", 512'(busy), 512'(0));
    checkVal("rst_done", 512'(done), 512'(0));
    checkVal("rst_dk", dk, '0);
    checkVal("rst_hmac_rst_n", 512'(hmac_rst_n), 512'(0));
    checkVal("rst_mode", 512'(hmac_mode), 512'(0));
    checkVal("rst_msg", hmac_msg, '0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] job iters=4");
    applyStimulus(4, {8{32'hA5C3_0F1E}}, 32'd7, nc);
    checkOutput("it4", nc, 1'b1, 1'b0);

    $display("[TB] job iters=3");
    applyStimulus(3, {8{32'h1234_5678}}, 32'd2, nc);
    checkOutput("it3", nc, 1'b1, 1'b0);

    $display("[TB] job iters=0");
    applyStimulus(0, {8{32'hDEAD_BEEF}}, 32'd9, nc);
    checkOutput("it0", nc, 1'b1, 1'b0);

    $display("[TB] job iters=1 byte salt");
    applyStimulus(1, s_bytes, 32'd1, nc);
    checkOutput("it1", nc, 1'b1, 1'b0);

    $display("[TB] job iters=2 random latency, stray done, start while busy");
    rnd_h    = 1'b1;
    stray_en = 1'b1;
    applyStimulus(2, {8{32'h0BAD_F00D}}, 32'd3, nc);
    checkOutput("rnd2", nc, 1'b0, 1'b1);
    rnd_h    = 1'b0;
    stray_en = 1'b0;

    $display("[TB] reset during second RUN of iters=5");
    applyStimulus(5, {8{32'h5555_AAAA}}, 32'd4, nc);
    hit = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (call_num == 2 && hmac_rst_n && busy) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkVal("mid_reached_run2", 512'(hit), 512'(1));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkVal("mid_hmac_rst_n", 512'(hmac_rst_n), 512'(0));
    checkVal("mid_busy", 512'(busy), 512'(0));
    checkVal("mid_dk", dk, '0);
    checkVal("mid_done", 512'(done), 512'(0));
    reset = 1'b0;
    exp_call_q.delete();
    exp_dk_q.delete();
    @(negedge clk);

    $display("[TB] job iters=2 after reset");
    applyStimulus(2, {8{32'h7777_1111}}, 32'd5, nc);
    checkOutput("post", nc, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
